// File: rtl/ixu_wb_arbiter_if.sv
// Writeback bus between the IXU lanes and the two-port register-file arbiter.
// The lane side drives the per-lane requests; the arbiter drives the write ports and stall.
interface ixu_wb_arbiter_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32
);
    logic [NUM_LANES-1:0]        lane_wr_en;
    logic [5*NUM_LANES-1:0]      lane_rd;
    logic [DATA_W*NUM_LANES-1:0] lane_data;

    logic                        wp0_en;
    logic [4:0]                  wp0_rd;
    logic [DATA_W-1:0]           wp0_data;
    logic                        wp1_en;
    logic [4:0]                  wp1_rd;
    logic [DATA_W-1:0]           wp1_data;
    logic                        stall;

    modport master (
        output lane_wr_en, lane_rd, lane_data,
        input  wp0_en, wp0_rd, wp0_data, wp1_en, wp1_rd, wp1_data, stall
    );

    modport slave (
        input  lane_wr_en, lane_rd, lane_data,
        output wp0_en, wp0_rd, wp0_data, wp1_en, wp1_rd, wp1_data, stall
    );
endinterface

// File: rtl/ixu_wb_arbiter.sv
// Merges NUM_LANES IXU writebacks onto two register-file write ports using a
// round-robin scan over per-lane pending slots; stalls the lanes while more than two are pending.
module ixu_wb_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    ixu_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_LANES);

    logic [NUM_LANES-1:0] slot_valid;
    logic [4:0]           slot_rd   [NUM_LANES];
    logic [DATA_W-1:0]    slot_data [NUM_LANES];
    logic [PTR_W-1:0]     rr_ptr;

    logic                 g0_vld;
    logic                 g1_vld;
    logic [PTR_W-1:0]     g0_sel;
    logic [PTR_W-1:0]     g1_sel;
    logic [PTR_W-1:0]     last_sel;
    logic [NUM_LANES-1:0] grant;
    logic                 stall_int;
    logic [NUM_LANES-1:0] cap_valid;
    logic                 wp0_on;
    logic                 wp1_on;

    always_comb begin : grant_scan
        int idx;
        int n_valid;
        g0_vld  = 1'b0;
        g1_vld  = 1'b0;
        g0_sel  = '0;
        g1_sel  = '0;
        grant   = '0;
        n_valid = 0;
        idx     = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = k + int'(rr_ptr);
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (slot_valid[idx]) begin
                n_valid = n_valid + 1;
                if (!g0_vld) begin
                    g0_vld     = 1'b1;
                    g0_sel     = PTR_W'(idx);
                    grant[idx] = 1'b1;
                end else if (!g1_vld) begin
                    g1_vld     = 1'b1;
                    g1_sel     = PTR_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
        stall_int = (n_valid > 2);
        last_sel  = g1_vld ? g1_sel : g0_sel;
    end

    // Only the highest-index lane targeting a given rd survives a capture,
    // which keeps rd unique across slots so grant order never reorders writes.
    always_comb begin
        cap_valid = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cap_valid[i] = bus.lane_wr_en[i] && (bus.lane_rd[5*i +: 5] != 5'd0);
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (bus.lane_wr_en[j] && (bus.lane_rd[5*j +: 5] == bus.lane_rd[5*i +: 5]))
                    cap_valid[i] = 1'b0;
            end
        end
    end

    assign wp0_on       = g0_vld && !rst;
    assign wp1_on       = g1_vld && !rst;
    assign bus.wp0_en   = wp0_on;
    assign bus.wp1_en   = wp1_on;
    assign bus.wp0_rd   = wp0_on ? slot_rd[g0_sel]   : 5'd0;
    assign bus.wp1_rd   = wp1_on ? slot_rd[g1_sel]   : 5'd0;
    assign bus.wp0_data = wp0_on ? slot_data[g0_sel] : '0;
    assign bus.wp1_data = wp1_on ? slot_data[g1_sel] : '0;
    assign bus.stall    = stall_int && !rst;

    // Without stall every valid slot is granted this cycle, so capture can
    // safely replace all slots at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                slot_rd[i]   <= 5'd0;
                slot_data[i] <= '0;
            end
        end else begin
            slot_valid <= slot_valid & ~grant;
            if (!stall_int) begin
                slot_valid <= cap_valid;
                for (int i = 0; i < NUM_LANES; i++) begin
                    slot_rd[i]   <= bus.lane_rd[5*i +: 5];
                    slot_data[i] <= bus.lane_data[DATA_W*i +: DATA_W];
                end
            end
            if (g0_vld) begin
                rr_ptr <= (int'(last_sel) == NUM_LANES - 1) ? '0 : last_sel + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ixu_wb_arbiter.sv
// Bench for ixu_wb_arbiter: directed scenarios plus randomized traffic against
// a pending-list reference model.
module tb_ixu_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ixu_wb_arbiter_if #(.NUM_LANES(N), .DATA_W(DW)) bus ();
    ixu_wb_arbiter #(.NUM_LANES(N), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model: pending writes per lane and the priority pointer
    bit             m_v  [N];
    logic [4:0]     m_rd [N];
    logic [DW-1:0]  m_d  [N];
    int             m_ptr = 0;
    int             m_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] port(input logic en, input logic [4:0] rd, input logic [DW-1:0] d);
        return {25'd0, en, rd, d};
    endfunction

    task automatic clear_lanes();
        bus.lane_wr_en = '0;
        bus.lane_rd    = '0;
        bus.lane_data  = '0;
    endtask

    task automatic set_lane(input int i, input logic e, input logic [4:0] r, input logic [DW-1:0] d);
        bus.lane_wr_en[i]       = e;
        bus.lane_rd[5*i +: 5]   = r;
        bus.lane_data[DW*i +: DW] = d;
    endtask

    // Compare outputs against the model mid-cycle, then compute the model's next state.
    task automatic sample(input string tag);
        logic [63:0] e0, e1;
        logic        es;
        int          idx, last, r, rj;
        bit          ok;
        @(negedge clk);
        m_q = {};
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (m_v[idx]) m_q.push_back(idx);
        end
        e0 = 64'd0;
        e1 = 64'd0;
        es = 1'b0;
        if (!rst) begin
            if (m_q.size() > 0) e0 = port(1'b1, m_rd[m_q[0]], m_d[m_q[0]]);
            if (m_q.size() > 1) e1 = port(1'b1, m_rd[m_q[1]], m_d[m_q[1]]);
            es = (m_q.size() > 2);
        end
        chk({tag, "_wp0"}, port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), e0);
        chk({tag, "_wp1"}, port(bus.wp1_en, bus.wp1_rd, bus.wp1_data), e1);
        chk({tag, "_stall"}, {63'd0, bus.stall}, {63'd0, es});

        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 1'b0; m_rd[i] = 5'd0; m_d[i] = '0;
            end
            m_ptr = 0;
        end else begin
            if (m_q.size() > 0) begin
                last = (m_q.size() > 1) ? m_q[1] : m_q[0];
                m_v[m_q[0]] = 1'b0;
                if (m_q.size() > 1) m_v[m_q[1]] = 1'b0;
                m_ptr = (last + 1) % N;
            end
            if (!es) begin
                for (int i = 0; i < N; i++) begin
                    r  = int'(bus.lane_rd[5*i +: 5]);
                    ok = bus.lane_wr_en[i] && (r != 0);
                    for (int j = i + 1; j < N; j++) begin
                        rj = int'(bus.lane_rd[5*j +: 5]);
                        if (bus.lane_wr_en[j] && rj == r) ok = 1'b0;
                    end
                    m_v[i]  = ok;
                    m_rd[i] = bus.lane_rd[5*i +: 5];
                    m_d[i]  = bus.lane_data[DW*i +: DW];
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string tag);
        sample(tag);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_lanes();
        cycle("rst");
        rst = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_lanes();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 1'b0; m_rd[i] = 5'd0; m_d[i] = '0;
        end
        #1;
        cycle("init");
        cycle("init");
        rst = 1'b0;
        cycle("idle");

        // two lanes, immediate dual grant
        set_lane(0, 1'b1, 5'd3, 32'hA);
        set_lane(1, 1'b1, 5'd4, 32'hB);
        cycle("s29_cap");
        clear_lanes();
        sample("s29_gnt");
        chk("s29_wp0_d", port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), port(1'b1, 5'd3, 32'hA));
        chk("s29_wp1_d", port(bus.wp1_en, bus.wp1_rd, bus.wp1_data), port(1'b1, 5'd4, 32'hB));
        chk("s29_stall_d", {63'd0, bus.stall}, 64'd0);
        advance();
        chk("s29_ptr", {62'd0, dut.rr_ptr}, 64'd2);

        // four lanes, stall for one cycle, inputs changed under stall are ignored
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 5'(i + 1), 32'h100 + i);
        cycle("s30_cap");
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 5'(i + 9), 32'hDEAD0 + i);
        sample("s30_c1");
        chk("s30_c1_wp0", port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), port(1'b1, 5'd1, 32'h100));
        chk("s30_c1_wp1", port(bus.wp1_en, bus.wp1_rd, bus.wp1_data), port(1'b1, 5'd2, 32'h101));
        chk("s30_c1_stall", {63'd0, bus.stall}, 64'd1);
        advance();
        clear_lanes();
        sample("s30_c2");
        chk("s30_c2_wp0", port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), port(1'b1, 5'd3, 32'h102));
        chk("s30_c2_wp1", port(bus.wp1_en, bus.wp1_rd, bus.wp1_data), port(1'b1, 5'd4, 32'h103));
        chk("s30_c2_stall", {63'd0, bus.stall}, 64'd0);
        advance();
        chk("s30_ptr", {62'd0, dut.rr_ptr}, 64'd0);
        cycle("s30_tail");

        // same-rd conflict in one bundle
        do_reset();
        set_lane(1, 1'b1, 5'd7, 32'h11);
        set_lane(3, 1'b1, 5'd7, 32'h33);
        cycle("s31_cap");
        clear_lanes();
        sample("s31_gnt");
        chk("s31_wp0_d", port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), port(1'b1, 5'd7, 32'h33));
        chk("s31_wp1_d", {63'd0, bus.wp1_en}, 64'd0);
        advance();

        // rd 0 is dropped
        do_reset();
        set_lane(2, 1'b1, 5'd0, 32'h55);
        cycle("s32_cap");
        clear_lanes();
        sample("s32_gnt");
        chk("s32_en", {62'd0, bus.wp0_en, bus.wp1_en}, 64'd0);
        chk("s32_stall_d", {63'd0, bus.stall}, 64'd0);
        advance();

        // reset mid-stall discards pending writes
        do_reset();
        set_lane(0, 1'b1, 5'd5, 32'h50);
        set_lane(1, 1'b1, 5'd6, 32'h60);
        set_lane(2, 1'b1, 5'd7, 32'h70);
        cycle("s33_cap");
        clear_lanes();
        sample("s33_stl");
        chk("s33_stall_d", {63'd0, bus.stall}, 64'd1);
        advance();
        rst = 1'b1;
        sample("s33_rst");
        chk("s33_rst_out", {bus.wp0_en, bus.wp1_en, bus.stall, bus.wp0_rd, bus.wp1_rd}, 64'd0);
        advance();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample("s33_post");
            chk("s33_post_en", {62'd0, bus.wp0_en, bus.wp1_en}, 64'd0);
            advance();
        end

        // wrap-around priority starting at lane 3
        do_reset();
        set_lane(2, 1'b1, 5'd5, 32'h22);
        cycle("s34_pre");
        clear_lanes();
        cycle("s34_pre_gnt");
        chk("s34_ptr3", {62'd0, dut.rr_ptr}, 64'd3);
        set_lane(0, 1'b1, 5'd8, 32'hA0);
        set_lane(1, 1'b1, 5'd9, 32'hA1);
        set_lane(3, 1'b1, 5'd10, 32'hA3);
        cycle("s34_cap");
        clear_lanes();
        sample("s34_c1");
        chk("s34_c1_wp0", port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), port(1'b1, 5'd10, 32'hA3));
        chk("s34_c1_wp1", port(bus.wp1_en, bus.wp1_rd, bus.wp1_data), port(1'b1, 5'd8, 32'hA0));
        advance();
        chk("s34_ptr1", {62'd0, dut.rr_ptr}, 64'd1);
        sample("s34_c2");
        chk("s34_c2_wp0", port(bus.wp0_en, bus.wp0_rd, bus.wp0_data), port(1'b1, 5'd9, 32'hA1));
        advance();
        chk("s34_ptr2", {62'd0, dut.rr_ptr}, 64'd2);

        // randomized traffic with small rd range to provoke conflicts and rd 0
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                set_lane(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            end
            cycle("rnd");
        end
        rst = 1'b0;
        clear_lanes();
        for (int c = 0; c < 4; c++) cycle("drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
